cond_issue_ctrl: RTL and testbench
==================================

Name: cond_issue_ctrl

Overview:
- Conditional-execution controller for the ID stage of the pipelined ARM core.
- Owns the NZCV status register and evaluates each ID instruction's 4-bit condition against current or forwarded flags.
- Decides per cycle whether the instruction issues, is squashed to a NOP, or stalls.
- Sequences the IF flush bubbles after a taken branch and keeps executed/squashed event counters.

Parameters:
FORWARD, 1, 1 = use EXE ALU flags directly when the EXE instruction sets flags; 0 = stall one cycle instead
BR_BUBBLES, 2, number of cycles flush_if is held after a taken branch (legal range 1..7)
CNT_W, 16, width of the event counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
hold  in  1  global pipeline freeze (memory wait)
id_valid  in  1  ID holds a real instruction
id_cond  in  4  condition field of the ID instruction
id_branch  in  1  ID instruction is a branch
exe_s  in  1  EXE instruction is valid and sets flags (S bit)
alu_flags  in  4  {N,Z,C,V} produced by the EXE ALU this cycle
sr  out  4  status register {N,Z,C,V}
issue  out  1  ID instruction passes its condition and advances
squash  out  1  ID instruction fails its condition and advances as a NOP
stall  out  1  hold IF/ID this cycle
flush_if  out  1  invalidate IF/ID contents
exec_cnt  out  CNT_W  count of issued instructions
squash_cnt  out  CNT_W  count of squashed instructions

Behaviour:
- Reset (async, rst_n=0):
  - sr=0, state=RUN, bubble counter=0, exec_cnt=0, squash_cnt=0.
  - issue, squash, stall and flush_if all read 0.
- Condition decode, on flags f. All conditions except LE are exact functions of f:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z&(N!=V) (core-wide encoding, kept deliberately).
  - 1110 AL 1; 1111 NV 0.
- Effective flags f:
  - FORWARD=1: exe_s ? alu_flags : sr.
  - FORWARD=0: sr.
- sr update: on the rising edge, if exe_s && !hold then sr <= alu_flags; otherwise sr holds.
- hold=1 overrides everything:
  - issue=squash=flush_if=0, stall=1.
  - state, bubble counter, counters and sr are frozen.
- State RUN:
  - id_valid=0: all outputs 0.
  - FORWARD=0 && exe_s && id_cond!=1110: stall=1, go to WAIT. Flags resolve next cycle from the updated sr.
  - Otherwise pass = eval(id_cond, f).
  - pass=1: issue=1, exec_cnt++.
  - pass=0: squash=1, squash_cnt++.
  - pass && id_branch: also flush_if=1, bubble counter loaded with BR_BUBBLES-1, go to FLUSH if BR_BUBBLES>1, else stay in RUN.
- State WAIT:
  - Evaluate as in RUN using sr, never stalling again.
  - Then go to RUN, or to FLUSH for a taken branch.
- State FLUSH:
  - flush_if=1; id_valid is ignored (no issue/squash, no count).
  - Counter decrements each cycle; go to RUN when it reaches 0.
  - A new exe_s still updates sr.
- Counters saturate at all-ones and never wrap.
- Outputs issue, squash, stall and flush_if are combinational from the state and inputs; issue and squash are mutually exclusive.
- Reset mid-FLUSH or mid-WAIT returns to RUN immediately and drops flush_if asynchronously.

Decomposition:
- Package cond_pkg:
  - 4-bit condition constants COND_EQ..COND_NV.
  - Flag bit indices N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
  - State enum {RUN, WAIT, FLUSH}.
- Sub-module cond_eval (combinational): inputs cond[3:0] and flags[3:0], output pass. Instantiated once.
- The FSM, sr, bubble counter and event counters live in cond_issue_ctrl. Target size ~200 lines.

Test Plan:
- Reset, then id_valid=1, id_cond=1110 (AL) -> issue=1, squash=0, exec_cnt=1, sr=0000.
- FORWARD=1: exe_s=1, alu_flags=0100 (Z), same cycle id_cond=0000 (EQ) -> issue=1; next cycle sr=0100; then id_cond=0001 (NE) -> squash=1, squash_cnt=1.
- FORWARD=0: same stimulus -> stall=1 for one cycle, then issue=1 from sr=0100; exec_cnt increments exactly once.
- BR_BUBBLES=2: taken branch with AL -> flush_if=1 for 2 cycles; id_valid during the second cycle is not counted; back to RUN on the third cycle.
- hold=1 for 3 cycles with exe_s=1 and alu_flags=1001 -> sr, counters and state are unchanged, stall=1, issue=0; after release, behaviour resumes identically.
- Counters preset near saturation via 65535 AL issues -> exec_cnt stays 16'hFFFF; rst_n pulsed low mid-FLUSH -> flush_if=0 and all counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared constants and types for the ID-stage conditional-execution controller.
package cond_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned COND_W = 4;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_eval
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[N_IDX];
  assign w_z = flags[Z_IDX];
  assign w_c = flags[C_IDX];
  assign w_v = flags[V_IDX];

  // LE intentionally uses the core-wide Z&(N!=V) encoding, not the inverse of GT.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !w_c || w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = w_z && (w_n != w_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// ID-stage issue/squash/stall control with NZCV ownership, branch flush bubbles
// and saturating executed/squashed event counters.
module cond_issue_ctrl
  import cond_pkg::*;
#(
  parameter bit          FORWARD    = 1'b1,
  parameter int unsigned BR_BUBBLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [COND_W-1:0] id_cond,
  input  logic              id_branch,
  input  logic              exe_s,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] sr,
  output logic              issue,
  output logic              squash,
  output logic              stall,
  output logic              flush_if,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam int unsigned       BUB_W    = 3;
  localparam logic [BUB_W-1:0]  BUB_LOAD = BUB_W'(BR_BUBBLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e             r_state, w_state_nxt;
  logic [BUB_W-1:0]   r_bub, w_bub_nxt;
  logic [FLAG_W-1:0]  r_sr;
  logic [CNT_W-1:0]   r_exec, r_squash;
  logic [FLAG_W-1:0]  w_flags;
  logic               w_pass;
  logic               w_exec_inc, w_squash_inc;

  // WAIT is only reachable with FORWARD=0, so it always sees sr here.
  assign w_flags = (FORWARD && exe_s) ? alu_flags : r_sr;

  cond_eval u_eval (
    .cond  (id_cond),
    .flags (w_flags),
    .pass  (w_pass)
  );

  // Next-state and per-cycle decision; all outputs forced low while in reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_bub_nxt    = r_bub;
    issue        = 1'b0;
    squash       = 1'b0;
    stall        = 1'b0;
    flush_if     = 1'b0;
    w_exec_inc   = 1'b0;
    w_squash_inc = 1'b0;
    if (!rst_n) begin
      w_state_nxt = RUN;
    end else if (hold) begin
      stall = 1'b1;
    end else begin
      case (r_state)
        RUN, WAIT: begin
          w_state_nxt = RUN;
          if (id_valid) begin
            if (!FORWARD && exe_s && (id_cond != COND_AL) && (r_state == RUN)) begin
              stall       = 1'b1;
              w_state_nxt = WAIT;
            end else if (w_pass) begin
              issue      = 1'b1;
              w_exec_inc = 1'b1;
              if (id_branch) begin
                flush_if  = 1'b1;
                w_bub_nxt = BUB_LOAD;
                if (BR_BUBBLES > 1) w_state_nxt = FLUSH;
              end
            end else begin
              squash       = 1'b1;
              w_squash_inc = 1'b1;
            end
          end
        end
        FLUSH: begin
          flush_if  = 1'b1;
          w_bub_nxt = r_bub - BUB_W'(1);
          if (r_bub == BUB_W'(1)) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_bub    <= '0;
      r_sr     <= '0;
      r_exec   <= '0;
      r_squash <= '0;
    end else begin
      if (!hold) begin
        r_state <= w_state_nxt;
        r_bub   <= w_bub_nxt;
      end
      if (exe_s && !hold) r_sr <= alu_flags;
      if (w_exec_inc && (r_exec != CNT_MAX)) r_exec <= r_exec + CNT_W'(1);
      if (w_squash_inc && (r_squash != CNT_MAX)) r_squash <= r_squash + CNT_W'(1);
    end
  end

  assign sr         = r_sr;
  assign exec_cnt   = r_exec;
  assign squash_cnt = r_squash;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Randomized self-checking bench: instance 0 is FORWARD=1/BR_BUBBLES=2,
// instance 1 is FORWARD=0/BR_BUBBLES=3, both driven by the same stimulus.
module tb_cond_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold, id_valid, id_branch, exe_s;
  logic [3:0] id_cond, alu_flags;

  logic [3:0]  t_sr     [2];
  logic [1:0]  t_issue, t_squash, t_stall, t_flush;
  logic [15:0] t_exec   [2];
  logic [15:0] t_sq     [2];

  int n_err = 0;
  int n_chk = 0;

  // Reference state per instance
  logic [3:0] m_sr   [2];
  bit         m_wait [2];
  int         m_left [2];
  int         m_exec [2];
  int         m_sq   [2];
  int         m_br   [2] = '{2, 3};
  bit         m_fwd  [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  cond_issue_ctrl #(.FORWARD(1'b1), .BR_BUBBLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_cond(id_cond),
    .id_branch(id_branch), .exe_s(exe_s), .alu_flags(alu_flags), .sr(t_sr[0]),
    .issue(t_issue[0]), .squash(t_squash[0]), .stall(t_stall[0]), .flush_if(t_flush[0]),
    .exec_cnt(t_exec[0]), .squash_cnt(t_sq[0])
  );

  cond_issue_ctrl #(.FORWARD(1'b0), .BR_BUBBLES(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_cond(id_cond),
    .id_branch(id_branch), .exe_s(exe_s), .alu_flags(alu_flags), .sr(t_sr[1]),
    .issue(t_issue[1]), .squash(t_squash[1]), .stall(t_stall[1]), .flush_if(t_flush[1]),
    .exec_cnt(t_exec[1]), .squash_cnt(t_sq[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Condition truth from the architectural table: even codes test a predicate,
  // odd codes its negation, with LE as the one irregular entry.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1101) return z && (n != v);
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = 4'h0; m_wait[k] = 1'b0; m_left[k] = 0; m_exec[k] = 0; m_sq[k] = 0;
    end
  endtask

  // One clock: drive at negedge, check outputs, advance model at posedge, return at negedge.
  task automatic step(input bit h, input bit v, input logic [3:0] c, input bit b,
                      input bit e, input logic [3:0] a, input bit do_chk);
    logic [3:0] nx_sr [2];
    bit         nx_wait [2];
    int         nx_left [2], nx_exec [2], nx_sq [2];
    bit         iss, sq, st, fl, p;
    logic [3:0] f;
    hold = h; id_valid = v; id_cond = c; id_branch = b; exe_s = e; alu_flags = a;
    #1;
    for (int k = 0; k < 2; k++) begin
      iss = 0; sq = 0; st = 0; fl = 0;
      nx_sr[k]   = (e && !h) ? a : m_sr[k];
      nx_wait[k] = m_wait[k];
      nx_left[k] = m_left[k];
      nx_exec[k] = m_exec[k];
      nx_sq[k]   = m_sq[k];
      if (h) begin
        st = 1;
      end else if (m_left[k] > 0) begin
        fl = 1;
        nx_left[k] = m_left[k] - 1;
      end else if (!v) begin
        nx_wait[k] = 0;
      end else if (!m_fwd[k] && e && c != 4'hE && !m_wait[k]) begin
        st = 1;
        nx_wait[k] = 1;
      end else begin
        f = (m_fwd[k] && e) ? a : m_sr[k];
        p = cond_true(c, f);
        nx_wait[k] = 0;
        if (p) begin
          iss = 1;
          if (m_exec[k] < 65535) nx_exec[k] = m_exec[k] + 1;
          if (b) begin
            fl = 1;
            nx_left[k] = m_br[k] - 1;
          end
        end else begin
          sq = 1;
          if (m_sq[k] < 65535) nx_sq[k] = m_sq[k] + 1;
        end
      end
      if (do_chk) begin
        chk($sformatf("i%0d_issue", k),  32'(t_issue[k]),  32'(iss));
        chk($sformatf("i%0d_squash", k), 32'(t_squash[k]), 32'(sq));
        chk($sformatf("i%0d_stall", k),  32'(t_stall[k]),  32'(st));
        chk($sformatf("i%0d_flush", k),  32'(t_flush[k]),  32'(fl));
        chk($sformatf("i%0d_sr", k),     32'(t_sr[k]),     32'(m_sr[k]));
        chk($sformatf("i%0d_exec", k),   32'(t_exec[k]),   32'(m_exec[k]));
        chk($sformatf("i%0d_sqcnt", k),  32'(t_sq[k]),     32'(m_sq[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = nx_sr[k]; m_wait[k] = nx_wait[k]; m_left[k] = nx_left[k];
      m_exec[k] = nx_exec[k]; m_sq[k] = nx_sq[k];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hold = 0; id_valid = 0; id_cond = 4'h0; id_branch = 0;
    exe_s = 0; alu_flags = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_sr", 32'(t_sr[0]), 32'h0);
    chk("rst_exec", 32'(t_exec[0]), 32'h0);

    // AL issue out of reset
    step(0, 1, 4'hE, 0, 0, 4'h0, 1);
    chk("al_exec0", 32'(t_exec[0]), 32'd1);
    chk("al_exec1", 32'(t_exec[1]), 32'd1);

    // EQ with Z set by the EXE instruction: forward vs one-cycle stall
    step(0, 1, 4'h0, 0, 1, 4'b0100, 1);
    chk("fwd_sr", 32'(t_sr[0]), 32'h4);
    chk("fwd_exec0", 32'(t_exec[0]), 32'd2);
    chk("stall_exec1", 32'(t_exec[1]), 32'd1);
    step(0, 1, 4'h0, 0, 0, 4'h0, 1);
    chk("wait_exec1", 32'(t_exec[1]), 32'd2);
    step(0, 1, 4'h1, 0, 0, 4'h0, 1);
    chk("ne_sq0", 32'(t_sq[0]), 32'd1);
    chk("ne_sq1", 32'(t_sq[1]), 32'd1);

    // Taken branch, then an instruction during the bubble that must not count
    step(0, 1, 4'hE, 1, 0, 4'h0, 1);
    step(0, 1, 4'hE, 0, 0, 4'h0, 1);
    chk("flush_nocnt0", 32'(t_exec[0]), 32'd4);
    step(0, 1, 4'hE, 0, 0, 4'h0, 1);
    chk("post_flush0", 32'(t_exec[0]), 32'd5);
    chk("flush_nocnt1", 32'(t_exec[1]), 32'd3);

    // Hold freezes everything even with exe_s asserted
    repeat (3) step(1, 1, 4'hE, 0, 1, 4'b1001, 1);
    chk("hold_sr", 32'(t_sr[0]), 32'h4);
    chk("hold_exec", 32'(t_exec[0]), 32'd5);
    step(0, 1, 4'hE, 0, 0, 4'h0, 1);
    chk("resume_exec", 32'(t_exec[0]), 32'd6);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), 1);
    end

    // Drive exec_cnt into saturation
    for (int i = 0; i < 65540; i++) step(0, 1, 4'hE, 0, 0, 4'h0, 0);
    step(0, 1, 4'hE, 0, 0, 4'h0, 1);
    chk("sat_exec0", 32'(t_exec[0]), 32'hFFFF);
    chk("sat_exec1", 32'(t_exec[1]), 32'hFFFF);

    // Async reset in the middle of the flush bubble
    step(0, 1, 4'hE, 1, 0, 4'h0, 1);
    chk("in_flush0", 32'(t_flush[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_flush0", 32'(t_flush[0]), 32'h0);
    chk("rst_flush1", 32'(t_flush[1]), 32'h0);
    chk("rst_issue0", 32'(t_issue[0]), 32'h0);
    chk("rst_exec0", 32'(t_exec[0]), 32'h0);
    chk("rst_sqcnt1", 32'(t_sq[1]), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 4'hE, 0, 0, 4'h0, 1);
    chk("post_rst_exec0", 32'(t_exec[0]), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
